// File: rtl/mastermind_scorer.sv
// Mastermind scoring engine: latches a secret code and a guess, then scores
// the guess sequentially (exact-position pass over pegs, then a colour pass
// over every colour) and reports black/white pegs, turn count, win and
// game-over with a one-cycle result_valid pulse.
module mastermind_scorer #(
    parameter int PEGS       = 4,
    parameter int COLOR_BITS = 3,
    parameter int MAX_TURNS  = 10
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       load_code,
    input  logic [PEGS*COLOR_BITS-1:0] code_in,
    input  logic                       load_guess,
    input  logic [PEGS*COLOR_BITS-1:0] guess_in,
    input  logic                       compare,
    output logic                       busy,
    output logic                       result_valid,
    output logic [2:0]                 black,
    output logic [2:0]                 white,
    output logic [3:0]                 turn,
    output logic                       won,
    output logic                       game_over
);

    // Accumulators must hold 0..PEGS and are never narrower than 3 bits.
    localparam int ACC_W  = ($clog2(PEGS + 1) > 3) ? $clog2(PEGS + 1) : 3;
    localparam int PIDX_W = (PEGS > 1) ? $clog2(PEGS) : 1;

    localparam logic [ACC_W-1:0]  PEGS_A    = ACC_W'(PEGS);
    localparam logic [3:0]        MAX_T     = 4'(MAX_TURNS);
    localparam logic [PIDX_W-1:0] PEG_LAST  = PIDX_W'(PEGS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXACT  = 2'd1,
        COLOR  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [PEGS*COLOR_BITS-1:0] code_reg;
    logic [PEGS*COLOR_BITS-1:0] guess_reg;
    logic [COLOR_BITS-1:0]      code_peg  [PEGS];
    logic [COLOR_BITS-1:0]      guess_peg [PEGS];

    logic [PIDX_W-1:0]     peg_idx;
    logic [COLOR_BITS-1:0] color_idx;
    logic [ACC_W-1:0]      blk_acc;
    logic [ACC_W-1:0]      tot_acc;
    logic [ACC_W-1:0]      cnt_code;
    logic [ACC_W-1:0]      cnt_guess;
    logic [ACC_W-1:0]      white_diff;

    logic       start;
    logic       peg_last;
    logic       color_last;
    logic       exact_hit;
    logic [3:0] turn_next;
    logic       won_next;
    logic       over_next;

    function automatic logic [ACC_W-1:0] min_cnt(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Turn count never passes MAX_TURNS.
    function automatic logic [3:0] sat_inc_turn(input logic [3:0] t);
        return (t >= MAX_T) ? t : t + 4'd1;
    endfunction

    // Compare is only honoured when idle, game still running and no load pending.
    assign start      = (state == IDLE) && compare && !game_over && !load_code && !load_guess;
    assign peg_last   = (peg_idx == PEG_LAST);
    assign color_last = (color_idx == '1);
    assign busy       = (state != IDLE);
    assign exact_hit  = (code_peg[peg_idx] == guess_peg[peg_idx]);
    assign white_diff = tot_acc - blk_acc;
    assign turn_next  = sat_inc_turn(turn);
    assign won_next   = (blk_acc == PEGS_A);
    assign over_next  = won_next || (turn_next == MAX_T);

    // Unpack the latched operands into per-peg colour values.
    always_comb begin
        for (int k = 0; k < PEGS; k++) begin
            code_peg[k]  = code_reg[COLOR_BITS*k +: COLOR_BITS];
            guess_peg[k] = guess_reg[COLOR_BITS*k +: COLOR_BITS];
        end
    end

    // Count pegs of the current colour in code and guess.
    always_comb begin
        cnt_code  = '0;
        cnt_guess = '0;
        for (int k = 0; k < PEGS; k++) begin
            if (code_peg[k] == color_idx) begin
                cnt_code = cnt_code + ACC_W'(1);
            end
            if (guess_peg[k] == color_idx) begin
                cnt_guess = cnt_guess + ACC_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: exact pass, colour pass, one report cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = EXACT;
            EXACT:   if (peg_last)   state_next = COLOR;
            COLOR:   if (color_last) state_next = REPORT;
            REPORT:                  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Operand latches, accumulators and reported results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_reg     <= '0;
            guess_reg    <= '0;
            peg_idx      <= '0;
            color_idx    <= '0;
            blk_acc      <= '0;
            tot_acc      <= '0;
            black        <= '0;
            white        <= '0;
            turn         <= '0;
            won          <= 1'b0;
            game_over    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_code) begin
                        code_reg  <= code_in;
                        turn      <= '0;
                        won       <= 1'b0;
                        game_over <= 1'b0;
                        black     <= '0;
                        white     <= '0;
                    end
                    if (load_guess) begin
                        guess_reg <= guess_in;
                    end
                    if (start) begin
                        blk_acc   <= '0;
                        tot_acc   <= '0;
                        peg_idx   <= '0;
                        color_idx <= '0;
                    end
                end
                EXACT: begin
                    blk_acc <= blk_acc + ACC_W'(exact_hit);
                    peg_idx <= peg_idx + PIDX_W'(1);
                end
                COLOR: begin
                    tot_acc   <= tot_acc + min_cnt(cnt_code, cnt_guess);
                    color_idx <= color_idx + COLOR_BITS'(1);
                end
                REPORT: begin
                    result_valid <= 1'b1;
                    black        <= blk_acc[2:0];
                    white        <= white_diff[2:0];
                    turn         <= turn_next;
                    won          <= won_next;
                    game_over    <= over_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Scoreboard bench for mastermind_scorer: a reference model scores each
// accepted compare from the game rules and queues the expected result; a
// monitor pops and checks on every result_valid pulse.
module tb_mastermind_scorer;

    logic        clk;
    logic        resetn;
    logic        load_code;
    logic [11:0] code_in;
    logic        load_guess;
    logic [11:0] guess_in;
    logic        compare;
    logic        busy;
    logic        result_valid;
    logic [2:0]  black;
    logic [2:0]  white;
    logic [3:0]  turn;
    logic        won;
    logic        game_over;

    typedef struct packed {
        logic [2:0] b;
        logic [2:0] w;
        logic [3:0] t;
        logic       wn;
        logic       ov;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [11:0] m_code;
    logic [11:0] m_guess;
    int          m_turn;
    logic        m_won;
    logic        m_over;

    mastermind_scorer #(.PEGS(4), .COLOR_BITS(3), .MAX_TURNS(10)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load_code    (load_code),
        .code_in      (code_in),
        .load_guess   (load_guess),
        .guess_in     (guess_in),
        .compare      (compare),
        .busy         (busy),
        .result_valid (result_valid),
        .black        (black),
        .white        (white),
        .turn         (turn),
        .won          (won),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
        logic [11:0] v;
        v = {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
        return v;
    endfunction

    function automatic int peg(input logic [11:0] v, input int k);
        return int'((v >> (3 * k)) & 12'h7);
    endfunction

    // Game rules: black = same colour same place; white = common colours minus black.
    function automatic res_t score(input logic [11:0] c, input logic [11:0] g, input int t);
        int   nb;
        int   tot;
        int   hc[8];
        int   hg[8];
        res_t r;
        nb  = 0;
        tot = 0;
        for (int i = 0; i < 8; i++) begin hc[i] = 0; hg[i] = 0; end
        for (int k = 0; k < 4; k++) begin
            if (peg(c, k) == peg(g, k)) nb++;
            hc[peg(c, k)]++;
            hg[peg(g, k)]++;
        end
        for (int i = 0; i < 8; i++) tot += (hc[i] < hg[i]) ? hc[i] : hg[i];
        r.b  = 3'(nb);
        r.w  = 3'(tot - nb);
        r.t  = 4'(t);
        r.wn = (nb == 4);
        r.ov = (nb == 4) || (t == 10);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && result_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got b=%0d w=%0d t=%0d won=%0d over=%0d with nothing pending",
                         black, white, turn, won, game_over);
            end else begin
                res_t e;
                res_t a;
                e = exp_q.pop_front();
                a = '{b: black, w: white, t: turn, wn: won, ov: game_over};
                if (a != e) begin
                    bad++;
                    $display("FAIL result: got b=%0d w=%0d t=%0d won=%0d over=%0d expected b=%0d w=%0d t=%0d won=%0d over=%0d",
                             a.b, a.w, a.t, a.wn, a.ov, e.b, e.w, e.t, e.wn, e.ov);
                end
            end
        end
    end

    task automatic model_reset();
        m_code  = '0;
        m_guess = '0;
        m_turn  = 0;
        m_won   = 1'b0;
        m_over  = 1'b0;
    endtask

    // Wait for the result pulse, checking it arrives 13 edges after compare.
    task automatic wait_result(input int elapsed);
        int n;
        n = elapsed;
        while (n < 40 && !result_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!result_valid) begin
            total++;
            bad++;
            $display("FAIL latency: got no result_valid within %0d edges expected 13", n);
        end else begin
            check("latency", n, 13);
        end
    endtask

    // Drive strobes without touching the model (used while busy).
    task automatic drive_raw(input logic lc, input logic [11:0] c, input logic lg,
                             input logic [11:0] g, input logic cmp);
        @(negedge clk);
        load_code  = lc;
        code_in    = c;
        load_guess = lg;
        guess_in   = g;
        compare    = cmp;
        @(posedge clk);
        #1;
        load_code  = 1'b0;
        load_guess = 1'b0;
        compare    = 1'b0;
    endtask

    // One idle-state transaction: drive, update model, check immediate effects.
    task automatic step(input logic lc, input logic [11:0] c, input logic lg,
                        input logic [11:0] g, input logic cmp, input logic wait_res);
        logic accept;
        accept = cmp && !m_over && !lc && !lg;
        drive_raw(lc, c, lg, g, cmp);
        if (lc) begin
            m_code = c;
            m_turn = 0;
            m_won  = 1'b0;
            m_over = 1'b0;
            check("load_clear_black", int'(black), 0);
            check("load_clear_turn", int'(turn), 0);
            check("load_clear_over", int'(game_over), 0);
        end
        if (lg) m_guess = g;
        check("busy_after_cmp", int'(busy), int'(accept));
        if (accept) begin
            res_t r;
            m_turn++;
            r = score(m_code, m_guess, m_turn);
            m_won  = r.wn;
            m_over = r.ov;
            exp_q.push_back(r);
            if (wait_res) wait_result(0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        load_code  = 1'b0;
        code_in    = '0;
        load_guess = 1'b0;
        guess_in   = '0;
        compare    = 1'b0;
        model_reset();

        // Reset with random inputs toggling.
        repeat (4) begin
            @(negedge clk);
            load_code  = 1'($urandom);
            code_in    = 12'($urandom);
            load_guess = 1'($urandom);
            guess_in   = 12'($urandom);
            compare    = 1'($urandom);
        end
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_black", int'(black), 0);
        check("rst_white", int'(white), 0);
        check("rst_turn", int'(turn), 0);
        check("rst_won", int'(won), 0);
        check("rst_over", int'(game_over), 0);
        @(negedge clk);
        load_code = 1'b0; load_guess = 1'b0; compare = 1'b0;
        resetn = 1'b1;

        // Compare against all-zero operands.
        step(0, '0, 0, '0, 1, 1);

        // Perfect guess, then an ignored compare.
        step(1, pk(1, 2, 3, 4), 1, pk(1, 2, 3, 4), 0, 1);
        step(0, '0, 0, '0, 1, 1);
        step(0, '0, 0, '0, 1, 1);
        idle(16);

        // All colours right, no positions.
        step(1, pk(1, 2, 3, 4), 1, pk(4, 3, 2, 1), 0, 1);
        step(0, '0, 0, '0, 1, 1);

        // Duplicate colours.
        step(1, pk(1, 1, 2, 2), 1, pk(1, 2, 1, 3), 0, 1);
        step(0, '0, 0, '0, 1, 1);
        step(1, pk(5, 5, 5, 5), 1, pk(5, 0, 0, 0), 0, 1);
        step(0, '0, 0, '0, 1, 1);

        // Turn limit.
        step(1, pk(1, 2, 3, 4), 1, pk(0, 0, 0, 0), 0, 1);
        for (int i = 0; i < 10; i++) step(0, '0, 0, '0, 1, 1);
        check("limit_over", int'(game_over), 1);
        check("limit_won", int'(won), 0);
        check("limit_turn", int'(turn), 10);
        step(0, '0, 0, '0, 1, 1);
        idle(16);
        step(1, pk(1, 2, 3, 4), 0, '0, 0, 1);

        // Strobes while busy are ignored.
        step(1, pk(1, 2, 3, 4), 1, pk(4, 4, 1, 1), 0, 1);
        step(0, '0, 0, '0, 1, 0);
        idle(2);
        drive_raw(0, '0, 1, pk(1, 2, 3, 4), 1);
        wait_result(3);
        idle(16);
        step(0, '0, 0, '0, 1, 1);

        // Reset during the exact pass aborts without a result.
        step(0, '0, 0, '0, 1, 0);
        idle(2);
        #3;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(result_valid), 0);
        check("abort_black", int'(black), 0);
        check("abort_turn", int'(turn), 0);
        check("abort_over", int'(game_over), 0);
        idle(2);
        @(negedge clk);
        resetn = 1'b1;
        idle(20);

        // Randomized play.
        for (int r = 0; r < 80; r++) begin
            logic        lc;
            logic        lg;
            logic        cmp;
            logic [11:0] c;
            logic [11:0] g;
            int          span;
            span = ($urandom_range(0, 1) == 0) ? 2 : 7;
            c    = pk($urandom_range(0, span), $urandom_range(0, span),
                      $urandom_range(0, span), $urandom_range(0, span));
            g    = pk($urandom_range(0, span), $urandom_range(0, span),
                      $urandom_range(0, span), $urandom_range(0, span));
            lc   = ($urandom_range(0, 4) == 0);
            lg   = ($urandom_range(0, 1) == 0);
            cmp  = ($urandom_range(0, 3) != 0);
            step(lc, c, lg, g, cmp, 1);
            idle(2);
        end

        idle(20);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Scoring engine for the Mastermind game; the consumer side of the control FSM's load_code / load_guess / compare strobes.
- Holds the secret code and the current guess.
- On compare, scores the guess sequentially: black = exact position matches, white = right colour in the wrong position.
- Tracks turn count, win, and game-over, and reports each result with a one-cycle valid pulse.

Parameters:
- PEGS, 4: pegs per code/guess.
- COLOR_BITS, 3: bits per peg, giving 2^COLOR_BITS colours.
- MAX_TURNS, 10: guesses allowed before game_over.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- load_code  in  1  one-cycle strobe; latch code_in.
- code_in  in  PEGS*COLOR_BITS  secret code; peg k = bits [COLOR_BITS*k+COLOR_BITS-1 : COLOR_BITS*k].
- load_guess  in  1  one-cycle strobe; latch guess_in.
- guess_in  in  PEGS*COLOR_BITS  guess, same packing as code_in.
- compare  in  1  one-cycle strobe; start scoring the latched guess.
- busy  out  1  high while scoring (EXACT, COLOR, REPORT).
- result_valid  out  1  one-cycle pulse when black/white are updated.
- black  out  3  exact-match count, 0..PEGS.
- white  out  3  colour-only match count, 0..PEGS.
- turn  out  4  number of scored guesses since the last load_code.
- won  out  1  sticky; set when black == PEGS.
- game_over  out  1  sticky; set when won, or when turn reaches MAX_TURNS.

Behaviour:
- Reset (resetn low, asynchronous):
  - State returns to IDLE.
  - code_reg, guess_reg, black, white, turn, won, game_over, result_valid, busy all go to 0.
  - Reset asserted mid-scoring aborts the operation with no result_valid; the partial result is discarded.
- State machine: IDLE, EXACT, COLOR, REPORT.
- IDLE:
  - load_code: latch code; clear turn, won, game_over, black, white.
  - load_guess: latch guess.
  - compare: go to EXACT, but only if game_over == 0 and neither load strobe is high in the same cycle. Otherwise compare is ignored.
  - load_code and load_guess in the same cycle: both latch.
- EXACT (PEGS cycles, index i = 0..PEGS-1):
  - Each cycle, blk_acc += (code_reg peg i == guess_reg peg i).
  - After i == PEGS-1, go to COLOR.
- COLOR (2^COLOR_BITS cycles, colour c = 0..2^COLOR_BITS-1):
  - Each cycle, count code pegs equal to c (cc) and guess pegs equal to c (cg), combinationally across all pegs.
  - tot_acc += min(cc, cg).
  - After the last colour, go to REPORT.
- REPORT (one cycle):
  - result_valid = 1.
  - On entry: black <= blk_acc; white <= tot_acc - blk_acc; turn <= turn + 1.
  - won <= (blk_acc == PEGS).
  - game_over <= won_next OR (turn + 1 == MAX_TURNS).
  - Next state is IDLE.
  - Accumulators clear when EXACT is entered.
- Latency: result_valid is high in the cycle after the edge that is 1 + PEGS + 2^COLOR_BITS edges after the edge sampling compare (13 with defaults). black/white/turn/won/game_over change at that same edge.
- While busy:
  - load_code, load_guess and compare are all ignored.
  - Latched operands are stable for the whole computation.
- black/white hold their values until the next REPORT, load_code, or reset.
- turn saturates at MAX_TURNS. It cannot be exceeded, because compare is blocked once game_over is set.
- Width rules:
  - tot_acc is at least 3 bits and never exceeds PEGS.
  - white is never negative (tot_acc >= blk_acc by construction).
- compare with no prior load_code scores against code 0. This is legal.

Test Plan:
- Reset: hold resetn low with random inputs -> all outputs 0. Release, then compare with no loads -> black 4, white 0 (both operands 0).
- Perfect guess: code pegs{0..3} = {1,2,3,4}, same guess, compare -> result_valid exactly 13 edges after compare; black 4, white 0, turn 1, won 1, game_over 1. A further compare is ignored (no busy, no valid).
- All colour, no position: code {1,2,3,4}, guess {4,3,2,1} -> black 0, white 4, turn 1, won 0.
- Duplicates: code {1,1,2,2}, guess {1,2,1,3} -> black 1, white 2. Then code {5,5,5,5}, guess {5,0,0,0} -> black 1, white 0.
- Turn limit: code {1,2,3,4}, ten guesses of {0,0,0,0} -> each gives black 0, white 0. game_over rises with the 10th result, won 0. 11th compare produces nothing. load_code then clears turn and game_over.
- Protection: compare, then load_guess {1,2,3,4} and a second compare 3 cycles later -> both ignored; result uses the original guess; only one result_valid. Then pulse resetn low during EXACT -> immediate IDLE, all outputs 0, no result_valid.
